// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: eight one-entry holding buffers feeding a round-robin
// picker that drives a registered broadcast. Optional feature macro: CDB_CONFLICT_CNT_EN.
module cdb_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        req_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  req_tag,
    input  logic [NUM_SRC*DATA_W-1:0] req_data,
    output logic [NUM_SRC-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [2:0]                cdb_src,
    output logic                      tag_err,
    output logic [15:0]               cdb_conflict_cnt
);

    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] full;
    logic [TAG_W-1:0]   buf_tag  [NUM_SRC];
    logic [DATA_W-1:0]  buf_data [NUM_SRC];
    logic [SRC_W-1:0]   ptr;

    logic [NUM_SRC-1:0] grant;
    logic [SRC_W-1:0]   win;
    logic               any_grant;
    logic [SRC_W-1:0]   idx;

    // Search starts just after the last winner; offset NUM_SRC wraps back to ptr itself.
    always_comb begin
        grant     = '0;
        win       = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = ptr + SRC_W'(k);
            if (!any_grant && full[idx]) begin
                any_grant  = 1'b1;
                win        = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    assign req_ready = ~full | grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            tag_err <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_tag[i]  <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant[i]) begin
                    full[i] <= 1'b0;
                end
                // Tag 0 is consumed but never held, so it can never reach the bus.
                if (req_valid[i] && req_ready[i]) begin
                    if (req_tag[i*TAG_W +: TAG_W] != '0) begin
                        full[i]     <= 1'b1;
                        buf_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
                        buf_data[i] <= req_data[i*DATA_W +: DATA_W];
                    end else begin
                        tag_err <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= SRC_W'(NUM_SRC - 1);
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (any_grant) begin
            ptr       <= win;
            cdb_valid <= 1'b1;
            cdb_tag   <= buf_tag[win];
            cdb_data  <= buf_data[win];
            cdb_src   <= 3'(win);
        end else begin
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_CONFLICT_CNT_EN
    localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);
    logic [15:0] conflict_cnt;

    // Clearing the lowest set bit leaves something only when two or more buffers are full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (|(full & (full - ONE)) && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign cdb_conflict_cnt = conflict_cnt;
`else
    assign cdb_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; expected values are hand-computed.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req_valid;
    logic [31:0] req_tag;
    logic [255:0] req_data;
    logic [7:0]  req_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [2:0]  cdb_src;
    logic        tag_err;
    logic [15:0] cdb_conflict_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] exp_cnt;

    cdb_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_tag          (req_tag),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data),
        .cdb_src          (cdb_src),
        .tag_err          (tag_err),
        .cdb_conflict_cnt (cdb_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic [3:0] tag, input logic [31:0] data);
        req_valid[i]         = 1'b1;
        req_tag[i*4 +: 4]    = tag;
        req_data[i*32 +: 32] = data;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    // Called one time unit after a rising edge, so reset toggles well between edges.
    task automatic pulseReset();
        req_valid = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
        #12;
        checkOutput("rst_valid", 32'(cdb_valid), 32'd0);
        checkOutput("rst_tag", 32'(cdb_tag), 32'd0);
        checkOutput("rst_data", cdb_data, 32'd0);
        checkOutput("rst_src", 32'(cdb_src), 32'd0);
        checkOutput("rst_tag_err", 32'(tag_err), 32'd0);
        checkOutput("rst_cnt", 32'(cdb_conflict_cnt), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'hFF);
        rst_n = 1'b1;
        tick();

        // Single source 3
        applyStimulus(3, 4'd5, 32'h1234);
        tick();
        req_valid = '0;
        checkOutput("single_not_yet", 32'(cdb_valid), 32'd0);
        tick();
        checkOutput("single_valid", 32'(cdb_valid), 32'd1);
        checkOutput("single_tag", 32'(cdb_tag), 32'd5);
        checkOutput("single_data", cdb_data, 32'h1234);
        checkOutput("single_src", 32'(cdb_src), 32'd3);
        tick();
        checkOutput("single_drop", 32'(cdb_valid), 32'd0);
        checkOutput("single_hold_tag", 32'(cdb_tag), 32'd5);

        // Simultaneous 0, 2, 7 after reset
        pulseReset();
        tick();
        applyStimulus(0, 4'd1, 32'hA0);
        applyStimulus(2, 4'd3, 32'hA2);
        applyStimulus(7, 4'd8, 32'hA7);
        tick();
        req_valid = '0;
        tick();
        checkOutput("sim_v0", 32'(cdb_valid), 32'd1);
        checkOutput("sim_src0", 32'(cdb_src), 32'd0);
        checkOutput("sim_data0", cdb_data, 32'hA0);
        tick();
        checkOutput("sim_src2", 32'(cdb_src), 32'd2);
        checkOutput("sim_tag2", 32'(cdb_tag), 32'd3);
        tick();
        checkOutput("sim_src7", 32'(cdb_src), 32'd7);
        checkOutput("sim_tag7", 32'(cdb_tag), 32'd8);
        tick();
        checkOutput("sim_done", 32'(cdb_valid), 32'd0);
`ifdef CDB_CONFLICT_CNT_EN
        exp_cnt = 16'd2;
`else
        exp_cnt = 16'd0;
`endif
        checkOutput("sim_conflict_cnt", 32'(cdb_conflict_cnt), 32'(exp_cnt));

        // Fairness: all sources valid continuously
        pulseReset();
        tick();
        for (int i = 0; i < 8; i++) applyStimulus(i, 4'(i + 1), 32'h100 + 32'(i));
        tick();
        checkOutput("fair_ready_first", 32'(req_ready), 32'h01);
        for (int k = 0; k < 9; k++) begin
            tick();
            checkOutput("fair_valid", 32'(cdb_valid), 32'd1);
            checkOutput("fair_src", 32'(cdb_src), 32'(k % 8));
            checkOutput("fair_tag", 32'(cdb_tag), 32'((k % 8) + 1));
            checkOutput("fair_ready", 32'(req_ready), 32'(8'd1 << ((k + 1) % 8)));
        end
        req_valid = '0;

        // Backpressure on source 1
        pulseReset();
        tick();
        applyStimulus(0, 4'd2, 32'h5555);
        applyStimulus(1, 4'd6, 32'hAAAA);
        tick();
        req_valid[0] = 1'b0;
        applyStimulus(1, 4'd9, 32'hBBBB);
        checkOutput("bp_ready", 32'(req_ready), 32'hFD);
        tick();
        req_valid = '0;
        checkOutput("bp_src0", 32'(cdb_src), 32'd0);
        checkOutput("bp_tag0", 32'(cdb_tag), 32'd2);
        tick();
        checkOutput("bp_src1", 32'(cdb_src), 32'd1);
        checkOutput("bp_tag1", 32'(cdb_tag), 32'd6);
        checkOutput("bp_data1", cdb_data, 32'hAAAA);
        tick();
        checkOutput("bp_done", 32'(cdb_valid), 32'd0);

        // Tag 0 from source 4
        applyStimulus(4, 4'd0, 32'hDEAD);
        tick();
        req_valid = '0;
        checkOutput("tag0_err", 32'(tag_err), 32'd1);
        checkOutput("tag0_ready", 32'(req_ready), 32'hFF);
        tick();
        checkOutput("tag0_no_valid", 32'(cdb_valid), 32'd0);
        tick();
        tick();
        checkOutput("tag0_sticky", 32'(tag_err), 32'd1);
        checkOutput("tag0_no_valid2", 32'(cdb_valid), 32'd0);
        pulseReset();
        checkOutput("tag0_cleared", 32'(tag_err), 32'd0);

        // Reset mid-run with three buffers full
        tick();
        applyStimulus(1, 4'd3, 32'h11);
        applyStimulus(3, 4'd4, 32'h33);
        applyStimulus(5, 4'd7, 32'h55);
        tick();
        req_valid = '0;
        tick();
        checkOutput("mid_pre_src", 32'(cdb_src), 32'd1);
        checkOutput("mid_pre_valid", 32'(cdb_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(cdb_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(req_ready), 32'hFF);
        rst_n = 1'b1;
        tick();
        checkOutput("mid_no_stale1", 32'(cdb_valid), 32'd0);
        tick();
        checkOutput("mid_no_stale2", 32'(cdb_valid), 32'd0);
        applyStimulus(6, 4'hC, 32'hC6);
        tick();
        req_valid = '0;
        tick();
        checkOutput("mid_new_valid", 32'(cdb_valid), 32'd1);
        checkOutput("mid_new_src", 32'(cdb_src), 32'd6);
        checkOutput("mid_new_tag", 32'(cdb_tag), 32'hC);
        checkOutput("mid_new_data", cdb_data, 32'hC6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
